// File: rtl/snitch_acc_pkg.sv
// Shared types and ID-width helpers for the accelerator-port arbiter.
// Struct typedef macros take the ID width so core-side and unit-side variants share one layout.
`define SNITCH_ACC_TYPEDEF_REQ(req_t, id_w) \
  typedef struct packed { \
    logic [31:0]       addr; \
    logic [(id_w)-1:0] id; \
    logic [31:0]       data_op; \
    logic [31:0]       data_arga; \
    logic [31:0]       data_argb; \
    logic [31:0]       data_argc; \
  } req_t;

`define SNITCH_ACC_TYPEDEF_RSP(rsp_t, id_w) \
  typedef struct packed { \
    logic [(id_w)-1:0] id; \
    logic              error; \
    logic [31:0]       data; \
  } rsp_t;

package snitch_acc_pkg;

  // A single core still carries a 1-bit (zero) index prefix.
  function automatic int unsigned acc_log_cores(input int unsigned core_count);
    return (core_count > 1) ? int'($clog2(core_count)) : 1;
  endfunction

  function automatic int unsigned acc_id_ext(input int unsigned id_width, input int unsigned core_count);
    return id_width + acc_log_cores(core_count);
  endfunction

endpackage

// File: rtl/snitch_acc_credit_cnt.sv
// Per-core outstanding-transaction counter, saturating at MaxOutstanding and at zero.
module snitch_acc_credit_cnt #(
  parameter int unsigned  MaxOutstanding = 4,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic credit_avail_o,
  output logic credit_nonzero_o
);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && !dec_i && (r_cnt != CntW'(MaxOutstanding))) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec_i && !inc_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign credit_avail_o   = (r_cnt < CntW'(MaxOutstanding));
  assign credit_nonzero_o = (r_cnt != '0);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(dec_i && !inc_i && (r_cnt == '0)));

endmodule

// File: rtl/snitch_acc_arbiter.sv
// Round-robin sharing of one accelerator port among CoreCount cores; core index prefixes the request ID.
// Optional per-core stall-cycle counters are built when SNITCH_ACC_ARB_STALL_CNT_EN is defined.
module snitch_acc_arbiter
  import snitch_acc_pkg::*;
#(
  parameter int unsigned  CoreCount      = 4,
  parameter int unsigned  IdWidth        = 5,
  parameter int unsigned  MaxOutstanding = 4,
  localparam int unsigned LogCoreCount   = acc_log_cores(CoreCount),
  localparam int unsigned SfuIdWidth     = acc_id_ext(IdWidth, CoreCount),
  localparam int unsigned CoreReqW       = IdWidth + 160,
  localparam int unsigned SfuReqW        = SfuIdWidth + 160,
  localparam int unsigned CoreRspW       = IdWidth + 33,
  localparam int unsigned SfuRspW        = SfuIdWidth + 33
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [CoreCount-1:0][CoreReqW-1:0] core_req_i,
  input  logic [CoreCount-1:0]               core_qvalid_i,
  output logic [CoreCount-1:0]               core_qready_o,
  output logic [CoreCount-1:0][CoreRspW-1:0] core_rsp_o,
  output logic [CoreCount-1:0]               core_pvalid_o,
  input  logic [CoreCount-1:0]               core_pready_i,
  output logic [SfuReqW-1:0]                 sfu_req_o,
  output logic                               sfu_qvalid_o,
  input  logic                               sfu_qready_i,
  input  logic [SfuRspW-1:0]                 sfu_rsp_i,
  input  logic                               sfu_pvalid_i,
  output logic                               sfu_pready_o,
  output logic                               rsp_misroute_o,
  output logic [CoreCount-1:0][31:0]         stall_cnt_o
);

  `SNITCH_ACC_TYPEDEF_REQ(core_req_t, IdWidth)
  `SNITCH_ACC_TYPEDEF_REQ(sfu_req_t, SfuIdWidth)
  `SNITCH_ACC_TYPEDEF_RSP(sfu_rsp_t, SfuIdWidth)

  // Returns {found, index} of the first eligible core at or after ptr, wrapping.
  function automatic logic [LogCoreCount:0] rr_pick(input logic [CoreCount-1:0]    elig,
                                                    input logic [LogCoreCount-1:0] ptr);
    logic [LogCoreCount:0] res;
    logic [CoreCount-1:0]  rot;
    int unsigned           idx;
    res = '0;
    for (int k = CoreCount - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % CoreCount;
      rot = elig >> idx;
      if (rot[0]) res = {1'b1, LogCoreCount'(idx)};
    end
    return res;
  endfunction

  logic [LogCoreCount-1:0] r_rr_q;
  logic                    r_full_q;
  sfu_req_t                r_req;

  logic [LogCoreCount-1:0] w_grant_idx, w_rr_next, w_rsp_sel;
  logic                    w_found, w_stage_free, w_req_hs, w_sel_valid;
  logic [CoreCount-1:0]    w_eligible, w_credit_avail, w_credit_nz, w_req_fire, w_rsp_fire;
  core_req_t               w_core_req;
  sfu_req_t                w_req_next;
  sfu_rsp_t                w_sfu_rsp;

  assign w_eligible               = core_qvalid_i & w_credit_avail;
  assign {w_found, w_grant_idx}   = rr_pick(w_eligible, r_rr_q);
  assign w_stage_free             = !r_full_q || sfu_qready_i;
  assign w_req_hs                 = w_found && w_stage_free;
  assign core_qready_o            = w_req_hs ? (CoreCount'(1) << w_grant_idx) : '0;
  assign w_rr_next                = (w_grant_idx == LogCoreCount'(CoreCount - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_core_req               = core_req_t'(core_req_i[w_grant_idx]);

  always_comb begin
    w_req_next           = '0;
    w_req_next.addr      = w_core_req.addr;
    w_req_next.id        = {w_grant_idx, w_core_req.id};
    w_req_next.data_op   = w_core_req.data_op;
    w_req_next.data_arga = w_core_req.data_arga;
    w_req_next.data_argb = w_core_req.data_argb;
    w_req_next.data_argc = w_core_req.data_argc;
  end

  // The stage only reloads when free, which keeps sfu_req_o stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_q   <= '0;
      r_full_q <= 1'b0;
      r_req    <= '0;
    end else if (w_req_hs) begin
      r_rr_q   <= w_rr_next;
      r_full_q <= 1'b1;
      r_req    <= w_req_next;
    end else if (sfu_qready_i) begin
      r_full_q <= 1'b0;
    end
  end

  assign sfu_req_o    = r_req;
  assign sfu_qvalid_o = r_full_q;

  assign w_sfu_rsp      = sfu_rsp_t'(sfu_rsp_i);
  assign w_rsp_sel      = w_sfu_rsp.id[SfuIdWidth-1:IdWidth];
  assign w_sel_valid    = (32'(w_rsp_sel) < 32'(CoreCount));
  assign rsp_misroute_o = sfu_pvalid_i && !w_sel_valid;

  // Responses to a core holding no credit (e.g. issued before a reset) are swallowed.
  always_comb begin
    core_rsp_o    = '0;
    core_pvalid_o = '0;
    sfu_pready_o  = 1'b1;
    for (int i = 0; i < CoreCount; i++) begin
      core_rsp_o[i] = {w_sfu_rsp.id[IdWidth-1:0], w_sfu_rsp.error, w_sfu_rsp.data};
      if ((w_rsp_sel == LogCoreCount'(i)) && w_credit_nz[i]) begin
        core_pvalid_o[i] = sfu_pvalid_i;
        sfu_pready_o     = core_pready_i[i];
      end
    end
  end

  assign w_req_fire = core_qvalid_i & core_qready_o;
  assign w_rsp_fire = core_pvalid_o & core_pready_i;

  for (genvar g = 0; g < CoreCount; g++) begin : g_credit
    snitch_acc_credit_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_credit (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .inc_i           (w_req_fire[g]),
      .dec_i           (w_rsp_fire[g]),
      .credit_avail_o  (w_credit_avail[g]),
      .credit_nonzero_o(w_credit_nz[g])
    );
  end

`ifdef SNITCH_ACC_ARB_STALL_CNT_EN
  logic [CoreCount-1:0][31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < CoreCount; i++) begin
        if (core_qvalid_i[i] && !core_qready_o[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snitch_acc_arbiter.sv
// Directed bench for snitch_acc_arbiter: a 4-core/4-credit instance and a 3-core/2-credit instance.
module tb_snitch_acc_arbiter;

  `SNITCH_ACC_TYPEDEF_REQ(core_req_t, 5)
  `SNITCH_ACC_TYPEDEF_REQ(sfu_req_t, 7)
  `SNITCH_ACC_TYPEDEF_RSP(core_rsp_t, 5)
  `SNITCH_ACC_TYPEDEF_RSP(sfu_rsp_t, 7)

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  core_req_t [3:0]   a_core_req;
  logic [3:0]        a_qvalid, a_qready, a_pvalid, a_pready_c;
  core_rsp_t [3:0]   a_core_rsp;
  sfu_req_t          a_sfu_req;
  logic              a_sfu_qvalid, a_sfu_qready, a_sfu_pvalid, a_sfu_pready, a_misroute;
  sfu_rsp_t          a_sfu_rsp;
  logic [3:0][31:0]  a_stall;

  core_req_t [2:0]   b_core_req;
  logic [2:0]        b_qvalid, b_qready, b_pvalid, b_pready_c;
  core_rsp_t [2:0]   b_core_rsp;
  sfu_req_t          b_sfu_req;
  logic              b_sfu_qvalid, b_sfu_qready, b_sfu_pvalid, b_sfu_pready, b_misroute;
  sfu_rsp_t          b_sfu_rsp;
  logic [2:0][31:0]  b_stall;

  snitch_acc_arbiter #(.CoreCount(4), .IdWidth(5), .MaxOutstanding(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(a_core_req), .core_qvalid_i(a_qvalid), .core_qready_o(a_qready),
    .core_rsp_o(a_core_rsp), .core_pvalid_o(a_pvalid), .core_pready_i(a_pready_c),
    .sfu_req_o(a_sfu_req), .sfu_qvalid_o(a_sfu_qvalid), .sfu_qready_i(a_sfu_qready),
    .sfu_rsp_i(a_sfu_rsp), .sfu_pvalid_i(a_sfu_pvalid), .sfu_pready_o(a_sfu_pready),
    .rsp_misroute_o(a_misroute), .stall_cnt_o(a_stall)
  );

  snitch_acc_arbiter #(.CoreCount(3), .IdWidth(5), .MaxOutstanding(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(b_core_req), .core_qvalid_i(b_qvalid), .core_qready_o(b_qready),
    .core_rsp_o(b_core_rsp), .core_pvalid_o(b_pvalid), .core_pready_i(b_pready_c),
    .sfu_req_o(b_sfu_req), .sfu_qvalid_o(b_sfu_qvalid), .sfu_qready_i(b_sfu_qready),
    .sfu_rsp_i(b_sfu_rsp), .sfu_pvalid_i(b_sfu_pvalid), .sfu_pready_o(b_sfu_pready),
    .rsp_misroute_o(b_misroute), .stall_cnt_o(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_core_req = '0; a_qvalid = '0; a_pready_c = 4'hF; a_sfu_qready = 1'b0;
    a_sfu_rsp  = '0; a_sfu_pvalid = 1'b0;
    b_core_req = '0; b_qvalid = '0; b_pready_c = 3'h7; b_sfu_qready = 1'b0;
    b_sfu_rsp  = '0; b_sfu_pvalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    checks++; if (a_sfu_qvalid !== 1'b0) begin errors++; $display("FAIL reset_qvalid: got %b want 0", a_sfu_qvalid); end
    checks++; if (a_sfu_req !== '0) begin errors++; $display("FAIL reset_req: got %h want 0", a_sfu_req); end
    checks++; if (a_qready !== 4'b0) begin errors++; $display("FAIL reset_qready: got %b want 0000", a_qready); end
    checks++; if (a_misroute !== 1'b0) begin errors++; $display("FAIL reset_misroute: got %b want 0", a_misroute); end
    checks++; if (a_stall !== '0) begin errors++; $display("FAIL reset_stall: got %h want 0", a_stall); end
    checks++; if (b_sfu_qvalid !== 1'b0) begin errors++; $display("FAIL reset_b_qvalid: got %b want 0", b_sfu_qvalid); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_core();
    do_reset();
    a_sfu_qready  = 1'b1;
    a_core_req[2] = '{addr: 32'h1000, id: 5'd3, data_op: 32'h33, data_arga: 32'hA, data_argb: 32'hB, data_argc: 32'hC};
    a_qvalid      = 4'b0100;
    #1;
    checks++; if (a_qready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", a_qready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_sfu_qvalid !== 1'b1) begin errors++; $display("FAIL single_qvalid%0d: got %b want 1", k, a_sfu_qvalid); end
      checks++; if (a_sfu_req.id !== {2'd2, 5'(3 + k)}) begin errors++; $display("FAIL single_id%0d: got %h want %h", k, a_sfu_req.id, {2'd2, 5'(3 + k)}); end
      if (k == 0) begin
        checks++; if (a_sfu_req.addr !== 32'h1000 || a_sfu_req.data_argc !== 32'hC) begin errors++; $display("FAIL single_payload: got %h/%h want 1000/c", a_sfu_req.addr, a_sfu_req.data_argc); end
      end
      if (k < 2) a_core_req[2].id = 5'(4 + k);
      else a_qvalid = 4'b0;
    end
    tick();
    checks++; if (a_sfu_qvalid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", a_sfu_qvalid); end
    a_sfu_rsp    = '{id: {2'd2, 5'd4}, error: 1'b1, data: 32'hDEAD_BEEF};
    a_sfu_pvalid = 1'b1;
    #1;
    checks++; if (a_pvalid !== 4'b0100) begin errors++; $display("FAIL rsp_route: got %b want 0100", a_pvalid); end
    checks++; if (a_core_rsp[0].id !== 5'd4 || a_core_rsp[3].data !== 32'hDEAD_BEEF || a_core_rsp[1].error !== 1'b1) begin errors++; $display("FAIL rsp_payload: got %h want 4/deadbeef/1", a_core_rsp[0]); end
    checks++; if (a_sfu_pready !== 1'b1) begin errors++; $display("FAIL rsp_pready_hi: got %b want 1", a_sfu_pready); end
    a_pready_c[2] = 1'b0;
    #1;
    checks++; if (a_sfu_pready !== 1'b0) begin errors++; $display("FAIL rsp_pready_lo: got %b want 0", a_sfu_pready); end
    a_pready_c   = 4'hF;
    a_sfu_pvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    a_sfu_qready = 1'b1;
    for (int i = 0; i < 4; i++)
      a_core_req[i] = '{addr: 32'(i), id: 5'(10 + i), data_op: 32'h0, data_arga: 32'h0, data_argb: 32'h0, data_argc: 32'h0};
    a_qvalid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (a_qready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, a_qready, 4'(1 << (k % 4))); end
      tick();
      checks++; if (a_sfu_req.id !== {2'(k % 4), 5'(10 + k % 4)}) begin errors++; $display("FAIL rr_id%0d: got %h want %h", k, a_sfu_req.id, {2'(k % 4), 5'(10 + k % 4)}); end
    end
    a_qvalid = 4'b0;
  endtask

  task automatic test_credit_limit();
    do_reset();
    b_sfu_qready  = 1'b1;
    b_core_req[1] = '{addr: 32'h40, id: 5'd9, data_op: 32'h1, data_arga: 32'h2, data_argb: 32'h3, data_argc: 32'h4};
    b_qvalid      = 3'b010;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (b_qready !== 3'b010) begin errors++; $display("FAIL credit_issue%0d: got %b want 010", k, b_qready); end
      tick();
    end
    #1;
    checks++; if (b_qready !== 3'b000) begin errors++; $display("FAIL credit_stall: got %b want 000", b_qready); end
    b_sfu_rsp    = '{id: {2'd1, 5'd9}, error: 1'b0, data: 32'h55};
    b_sfu_pvalid = 1'b1;
    #1;
    checks++; if (b_pvalid !== 3'b010) begin errors++; $display("FAIL credit_rsp: got %b want 010", b_pvalid); end
    checks++; if (b_qready !== 3'b000) begin errors++; $display("FAIL credit_still_stalled: got %b want 000", b_qready); end
    tick();
    b_sfu_pvalid = 1'b0;
    #1;
    checks++; if (b_qready !== 3'b010) begin errors++; $display("FAIL credit_reenable: got %b want 010", b_qready); end
    b_qvalid = 3'b0;
  endtask

  task automatic test_stall();
    sfu_req_t exp;
    do_reset();
    a_core_req[0] = '{addr: 32'h2000, id: 5'd7, data_op: 32'h44, data_arga: 32'h1, data_argb: 32'h2, data_argc: 32'h3};
    a_core_req[3] = '{addr: 32'h3000, id: 5'd1, data_op: 32'h45, data_arga: 32'h4, data_argb: 32'h5, data_argc: 32'h6};
    exp           = '{addr: 32'h2000, id: {2'd0, 5'd7}, data_op: 32'h44, data_arga: 32'h1, data_argb: 32'h2, data_argc: 32'h3};
    a_qvalid      = 4'b1001;
    #1;
    checks++; if (a_qready !== 4'b0001) begin errors++; $display("FAIL stall_first_grant: got %b want 0001", a_qready); end
    tick();
`ifdef SNITCH_ACC_ARB_STALL_CNT_EN
    checks++; if (a_stall[0] !== 32'd0 || a_stall[3] !== 32'd1) begin errors++; $display("FAIL stall_cnt_start: got %0d/%0d want 0/1", a_stall[0], a_stall[3]); end
`else
    checks++; if (a_stall !== '0) begin errors++; $display("FAIL stall_cnt_start: got %h want 0", a_stall); end
`endif
    for (int k = 0; k < 5; k++) begin
      checks++; if (a_qready !== 4'b0) begin errors++; $display("FAIL stall_qready%0d: got %b want 0000", k, a_qready); end
      checks++; if (a_sfu_qvalid !== 1'b1 || a_sfu_req !== exp) begin errors++; $display("FAIL stall_req%0d: got %h want %h", k, a_sfu_req, exp); end
      tick();
    end
`ifdef SNITCH_ACC_ARB_STALL_CNT_EN
    checks++; if (a_stall[0] !== 32'd5 || a_stall[3] !== 32'd6) begin errors++; $display("FAIL stall_cnt_end: got %0d/%0d want 5/6", a_stall[0], a_stall[3]); end
`else
    checks++; if (a_stall !== '0) begin errors++; $display("FAIL stall_cnt_end: got %h want 0", a_stall); end
`endif
    a_sfu_qready = 1'b1;
    #1;
    checks++; if (a_qready !== 4'b1000) begin errors++; $display("FAIL stall_resume_grant: got %b want 1000", a_qready); end
    tick();
    checks++; if (a_sfu_req.id !== {2'd3, 5'd1}) begin errors++; $display("FAIL stall_resume_id: got %h want %h", a_sfu_req.id, {2'd3, 5'd1}); end
    a_qvalid = 4'b0;
  endtask

  task automatic test_misroute();
    do_reset();
    b_pready_c   = 3'b000;
    b_sfu_rsp    = '{id: {2'd3, 5'd1}, error: 1'b0, data: 32'h1};
    b_sfu_pvalid = 1'b1;
    #1;
    checks++; if (b_sfu_pready !== 1'b1) begin errors++; $display("FAIL misroute_pready: got %b want 1", b_sfu_pready); end
    checks++; if (b_pvalid !== 3'b000) begin errors++; $display("FAIL misroute_pvalid: got %b want 000", b_pvalid); end
    checks++; if (b_misroute !== 1'b1) begin errors++; $display("FAIL misroute_pulse: got %b want 1", b_misroute); end
    tick();
    b_sfu_pvalid = 1'b0;
    #1;
    checks++; if (b_misroute !== 1'b0) begin errors++; $display("FAIL misroute_clear: got %b want 0", b_misroute); end
    b_pready_c = 3'h7;
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    a_sfu_qready  = 1'b1;
    a_core_req[1] = '{addr: 32'h10, id: 5'd2, data_op: 32'h7, data_arga: 32'h8, data_argb: 32'h9, data_argc: 32'hA};
    a_qvalid      = 4'b0010;
    tick();
    tick();
    a_qvalid     = 4'b0;
    a_sfu_qready = 1'b0;
    #1;
    checks++; if (a_sfu_qvalid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got %b want 1", a_sfu_qvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_sfu_qvalid !== 1'b0 || a_sfu_req !== '0) begin errors++; $display("FAIL inflight_rst_req: got %b/%h want 0/0", a_sfu_qvalid, a_sfu_req); end
    checks++; if (a_qready !== 4'b0 || a_pvalid !== 4'b0 || a_misroute !== 1'b0) begin errors++; $display("FAIL inflight_rst_out: got %b/%b/%b want 0", a_qready, a_pvalid, a_misroute); end
    tick();
    rst_n = 1'b1;
    tick();
    a_sfu_rsp    = '{id: {2'd1, 5'd2}, error: 1'b0, data: 32'h77};
    a_sfu_pvalid = 1'b1;
    #1;
    checks++; if (a_pvalid !== 4'b0 || a_sfu_pready !== 1'b1) begin errors++; $display("FAIL late_rsp_drop: got %b/%b want 0000/1", a_pvalid, a_sfu_pready); end
    tick();
    tick();
    a_sfu_pvalid = 1'b0;
    a_sfu_qready = 1'b1;
    a_qvalid     = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (a_qready !== 4'b0010) begin errors++; $display("FAIL post_rst_issue%0d: got %b want 0010", k, a_qready); end
      tick();
    end
    #1;
    checks++; if (a_qready !== 4'b0) begin errors++; $display("FAIL post_rst_limit: got %b want 0000", a_qready); end
    a_qvalid = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_round_robin();
    test_credit_limit();
    test_stall();
    test_misroute();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snitch_acc_arbiter.md
# snitch_acc_arbiter

Shares one accelerator port (shared mul/div or another shared functional unit) among `CoreCount` cores in a hive. It forwards core requests through round-robin arbitration into a single registered request stage, prefixing the core index onto the transaction ID. Responses go back to the originating core by that ID prefix. Per-core credit counters cap each core's outstanding transactions so one core cannot fill the unit's pipeline.

## Interface
- `CoreCount`, 4, number of requesting cores (1..16)
- `IdWidth`, 5, core-side transaction ID width
- `MaxOutstanding`, 4, per-core in-flight limit (1..15)
- `core_req_t`, logic, core request struct: `addr[31:0]`, `id[IdWidth-1:0]`, `data_op[31:0]`, `data_arga/b/c`
- `sfu_req_t`, logic, same as `core_req_t` but with `id` widened to `IdWidth+LogCoreCount`
- `sfu_rsp_t`, logic, response struct: `id[IdWidth+LogCoreCount-1:0]`, `error`, `data`
- `core_rsp_t`, logic, response struct with `id[IdWidth-1:0]`
- `clk_i  in  1  clock`
- `rst_ni  in  1  asynchronous active-low reset`
- `core_req_i  in  CoreCount x core_req_t  per-core request payload`
- `core_qvalid_i / core_qready_o  in/out  CoreCount  request handshake`
- `core_rsp_o  out  CoreCount x core_rsp_t  response payload, broadcast`
- `core_pvalid_o / core_pready_i  out/in  CoreCount  response handshake`
- `sfu_req_o  out  sfu_req_t  registered request to the shared unit`
- `sfu_qvalid_o / sfu_qready_i  out/in  1  request handshake`
- `sfu_rsp_i  in  sfu_rsp_t  response from the shared unit`
- `sfu_pvalid_i / sfu_pready_o  in/out  1  response handshake`
- `rsp_misroute_o  out  1  one-cycle pulse when a response ID selects a nonexistent core`
- `stall_cnt_o  out  CoreCount x 32  per-core stall-cycle counters (see Configuration)`

## Operation
- `LogCoreCount = max(1, $clog2(CoreCount))`.
- Eligible core i: `core_qvalid_i[i] && credit[i] < MaxOutstanding`.
- Round-robin pick:
  - Search starts at pointer `rr_q` and takes the first eligible core at or after it, wrapping around.
  - On a core-side handshake, `rr_q` moves to granted+1, wrapping modulo `CoreCount`.
- Request stage is a single register with a `full_q` flag.
  - `core_qready_o[i] = grant[i] && (!full_q || sfu_qready_i)`. At most one bit is high.
  - On a core handshake the stage loads `{i, core id}` plus the payload unchanged, and `full_q` is set.
  - When the unit accepts and no new load happens in the same cycle, `full_q` is cleared.
- Stability: `sfu_req_o` holds constant while `sfu_qvalid_o && !sfu_qready_i`.
- Credits, per core (`snitch_acc_credit_cnt`):
  - +1 on a core request handshake.
  - −1 on a core response handshake.
  - Both in the same cycle: unchanged.
  - The count never exceeds `MaxOutstanding` and never underflows. Underflow is an assertion.
- Response routing:
  - `sel = sfu_rsp_i.id[IdWidth+LogCoreCount-1:IdWidth]`.
  - If `sel < CoreCount`: `core_pvalid_o[sel] = sfu_pvalid_i` and `sfu_pready_o = core_pready_i[sel]`.
  - If `sel >= CoreCount`: the response is dropped, `sfu_pready_o = 1`, and `rsp_misroute_o` pulses on the handshake.
  - All `core_rsp_o[i]` carry `id[IdWidth-1:0]`, `error` and `data` from `sfu_rsp_i`.
- `CoreCount == 1`: the arbiter degenerates to a pass-through. The ID still gets a 1-bit zero prefix.

## Timing
- Request latency: 1 cycle from the core handshake to `sfu_qvalid_o`. Throughput: 1 request/cycle while `sfu_qready_i` is high.
- Response path: purely combinational, 0 cycles.
- Reset values:
  - `sfu_qvalid_o = 0`, `sfu_req_o = '0`.
  - `rr_q = 0`, all credits 0, `full_q = 0`.
  - `rsp_misroute_o = 0`, `stall_cnt_o = 0`.
  - Combinational outputs follow from these values.
- Reset asserted mid-transaction: all state clears immediately. In-flight responses that arrive afterwards must not underflow credits; they are dropped with saturation at 0.
- No combinational path from `core_qvalid_i` to `core_qready_o` of another core, except through the arbitration grant.

## Configuration
- `SNITCH_ACC_ARB_STALL_CNT_EN`:
  - Defined: `stall_cnt_o[i]` increments each cycle in which `core_qvalid_i[i] && !core_qready_o[i]`. It saturates at `32'hFFFF_FFFF` and clears only on reset.
  - Undefined: `stall_cnt_o` is tied to `'0` and no counter flops are built. The port exists in both cases.

## Structure
- Package `snitch_acc_pkg`:
  - Parameterized typedef macros for core, SFU request and response structs.
  - `acc_id_ext` helper computing `IdWidth + LogCoreCount`.
- Sub-module `snitch_acc_credit_cnt`:
  - Saturating up/down counter.
  - Outputs `credit_avail_o`.
  - One instance per core.
- The round-robin pick is a local function.

## Test plan
- Single core 2, three back-to-back requests with ids 3, 4, 5, `sfu_qready_i = 1` → `sfu_req_o.id` = `{2'd2, 5'd3}`, `{2'd2, 5'd4}`, `{2'd2, 5'd5}` on consecutive cycles, starting 1 cycle after the first handshake.
- All four cores valid continuously, `sfu_qready_i = 1` → grant order 0, 1, 2, 3, 0, …, one grant per cycle.
- `MaxOutstanding = 2`, core 1 issues with responses withheld → third request stalls (`core_qready_o[1] = 0`). Returning one response with id `{1, x}` re-enables issue the next cycle.
- `sfu_qready_i` low for 5 cycles with the stage full → `sfu_req_o` stable, `core_qready_o` all 0, and with the macro defined `stall_cnt_o` of each valid core increases by 5.
- `CoreCount = 3`, response with `sel = 3` → `sfu_pready_o = 1`, all `core_pvalid_o = 0`, `rsp_misroute_o` pulses once.
- `rst_ni` dropped while two requests are in flight → all outputs 0 at once. After release, late responses leave credits at 0 and new requests issue normally.
